// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned shift-add multiplier (one bit per clock)
// feeding the architectural HI/LO register pair, with a combinational
// HI/LO read port for MFHI/MFLO.
//
// Handshake: Start is a request sampled on a rising Clk edge; it is taken
// only in IDLE or DONE (no backpressure signal, Start in MUL is dropped).
// Busy is high for the WIDTH cycles of iteration, Done pulses for one cycle
// once HI/LO hold the new product. Busy and Done are never high together.
module multu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   sum;

  // Partial-product add for this step; the carry bit shifts into P_hi MSB.
  always_comb begin
    sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  end

  // Control FSM plus datapath: accept, iterate, commit to HI/LO.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      a_reg <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts Start exactly like IDLE so MULTUs can run back to back.
          if (Start) begin
            a_reg <= dataA;
            p_lo  <= dataB;
            p_hi  <= '0;
            count <= '0;
            state <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          p_hi  <= sum[WIDTH:1];
          p_lo  <= {sum[0], p_lo[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST) begin
            // Commit the finished product on the same edge as the last step.
            hi    <= sum[WIDTH:1];
            lo    <= {sum[0], p_lo[WIDTH-1:1]};
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register.
  always_comb begin
    Busy      = (state == MUL);
    Done      = (state == DONE);
    state_dbg = state;
  end

  // MFHI/MFLO read path: 01 = HI, 10 = LO, anything else reads zero.
  always_comb begin
    HiLoOut = '0;
    case (Sel)
      2'b01:   HiLoOut = hi;
      2'b10:   HiLoOut = lo;
      default: HiLoOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Testbench for multu_hilo: table vectors, hand-written corner sequences and
// random operands, all checked against a 64-bit arithmetic model.
module tb_multu_hilo;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  data_a;
  logic [W-1:0]  data_b;
  logic [1:0]    sel;
  logic [W-1:0]  hilo_out;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  // Expected products, pushed when an operation is issued.
  logic [2*W-1:0] exp_q[$];
  // Model of the committed HI/LO pair.
  logic [W-1:0]   prev_hi;
  logic [W-1:0]   prev_lo;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  multu_hilo #(.WIDTH(W)) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .Start     (start),
    .dataA     (data_a),
    .dataB     (data_b),
    .Sel       (sel),
    .HiLoOut   (hilo_out),
    .Busy      (busy),
    .Done      (done),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive Start for one cycle (caller is at a negedge) and record the model product.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    data_a = a;
    data_b = b;
    exp_q.push_back(64'(a) * 64'(b));
    @(negedge clk);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
  endtask

  // Follow one operation until Done, checking Busy length, read-port behaviour
  // while busy, and the product in the Done cycle. Returns positioned in the
  // Done cycle. glitch_at >= 0 pulses Start (operands 1,1) on that busy cycle.
  task automatic wait_result(input int glitch_at, input string name,
                             output logic [W-1:0] got_hi, output logic [W-1:0] got_lo);
    int busy_cycles;
    bit seen;
    logic [63:0] exp;
    logic [W-1:0] exp_rd;
    busy_cycles = 0;
    seen = 1'b0;
    got_hi = '0;
    got_lo = '0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        busy_cycles++;
        sel = 2'(i % 4);
        #1;
        case (sel)
          2'b01:   exp_rd = prev_hi;
          2'b10:   exp_rd = prev_lo;
          default: exp_rd = '0;
        endcase
        check($sformatf("%s busy read sel=%0d", name, sel), 64'(hilo_out), 64'(exp_rd));
      end
      if (i == glitch_at) begin
        start  = 1'b1;
        data_a = 1;
        data_b = 1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
    check({name, " busy cycles"}, 64'(busy_cycles), 64'd32);
    check({name, " busy low in done"}, 64'(busy), 64'd0);
    sel = 2'b10; #1; got_lo = hilo_out;
    sel = 2'b01; #1; got_hi = hilo_out;
    sel = 2'b00; #1; check({name, " sel00 in done"}, 64'(hilo_out), 64'd0);
    sel = 2'b11; #1; check({name, " sel11 in done"}, 64'(hilo_out), 64'd0);
    if (exp_q.size() == 0) begin
      check({name, " expected queue empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      check({name, " product"}, {got_hi, got_lo}, exp);
      prev_hi = exp[63:32];
      prev_lo = exp[31:0];
    end
  endtask

  // Done must drop after a single cycle when no new Start is given.
  task automatic finish_op(input string name);
    @(negedge clk);
    check({name, " done one cycle"}, 64'(done), 64'd0);
    check({name, " idle not busy"}, 64'(busy), 64'd0);
  endtask

  // Count Busy/Done activity over n cycles; used to prove nothing runs.
  task automatic expect_quiet(input int n, input string name);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || done) act++;
    end
    check({name, " quiet cycles active"}, 64'(act), 64'd0);
  endtask

  logic [W-1:0] g_hi, g_lo;
  logic [W-1:0] ra, rb;

  initial begin
    vecs[0] = '{a: 32'd3,          b: 32'd5,          hi: 32'h0,        lo: 32'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  hi: 32'hFFFF_FFFE, lo: 32'h1};
    vecs[2] = '{a: 32'h8000_0000,  b: 32'd2,          hi: 32'h1,        lo: 32'h0};
    vecs[3] = '{a: 32'd7,          b: 32'd6,          hi: 32'h0,        lo: 32'd42};
    vecs[4] = '{a: 32'h0,          b: 32'h0001_2345,  hi: 32'h0,        lo: 32'h0};
    vecs[5] = '{a: 32'h1,          b: 32'hFFFF_FFFF,  hi: 32'h0,        lo: 32'hFFFF_FFFF};
    vecs[6] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  hi: 32'h1,        lo: 32'h0};
    vecs[7] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          hi: 32'h1,        lo: 32'hFFFF_FFFE};

    // Reset
    rst_n = 1'b0; start = 1'b0; data_a = '0; data_b = '0; sel = 2'b00;
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    sel = 2'b01; #1; check("reset hi", 64'(hilo_out), 64'd0);
    sel = 2'b10; #1; check("reset lo", 64'(hilo_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      issue(vecs[k].a, vecs[k].b);
      wait_result(-1, $sformatf("vec%0d", k), g_hi, g_lo);
      check($sformatf("vec%0d hi", k), 64'(g_hi), 64'(vecs[k].hi));
      check($sformatf("vec%0d lo", k), 64'(g_lo), 64'(vecs[k].lo));
      finish_op($sformatf("vec%0d", k));
    end

    // Start pulsed mid-multiply is ignored
    issue(32'd7, 32'd9);
    wait_result(10, "ignore_start", g_hi, g_lo);
    check("ignore_start lo", 64'(g_lo), 64'd63);
    expect_quiet(40, "ignore_start");

    // Preload 2x3, then 4x4: busy reads return 6, Done cycle returns 16
    issue(32'd2, 32'd3);
    wait_result(-1, "preload", g_hi, g_lo);
    finish_op("preload");
    issue(32'd4, 32'd4);
    wait_result(-1, "after_preload", g_hi, g_lo);
    check("after_preload lo", 64'(g_lo), 64'd16);
    finish_op("after_preload");

    // Asynchronous reset mid-multiply
    issue(32'd100, 32'd100);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    sel = 2'b01; #1; check("midreset hi", 64'(hilo_out), 64'd0);
    sel = 2'b10; #1; check("midreset lo", 64'(hilo_out), 64'd0);
    exp_q.delete();
    prev_hi = '0; prev_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(40, "midreset");
    issue(32'd7, 32'd6);
    wait_result(-1, "post_reset", g_hi, g_lo);
    check("post_reset lo", 64'(g_lo), 64'd42);
    finish_op("post_reset");

    // Back-to-back: Start held in the Done cycle
    issue(32'd5, 32'd5);
    wait_result(-1, "b2b_first", g_hi, g_lo);
    check("b2b_first lo", 64'(g_lo), 64'd25);
    issue(32'd10, 32'd10);
    check("b2b no idle gap", 64'(busy), 64'd1);
    wait_result(-1, "b2b_second", g_hi, g_lo);
    check("b2b_second lo", 64'(g_lo), 64'd100);
    finish_op("b2b_second");

    // Random operands against the arithmetic model
    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k % 5 == 0) ra = 32'($urandom_range(0, 15));
      issue(ra, rb);
      wait_result(-1, $sformatf("rand%0d", k), g_hi, g_lo);
      if ($urandom_range(0, 1) == 1) finish_op($sformatf("rand%0d", k));
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
